// File: rtl/countdown_sched_pkg.sv
// Shared types and the round-robin pick function for the countdown scheduler.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // Widest requester vector rr_pick accepts; the scheduler supports N <= MAX_N.
  localparam int MAX_N = 32;
  localparam int MAX_W = 5;

  // Returns the first index with req set, searching ptr, ptr+1, ... mod n.
  // Returns 0 when no request is set (caller only uses the result when |req).
  function automatic logic [MAX_W-1:0] rr_pick(
    input logic [MAX_N-1:0] req,
    input logic [MAX_W-1:0] ptr,
    input logic [MAX_W:0]   n
  );
    logic [MAX_W-1:0] win;
    logic [MAX_W:0]   sum;
    logic [MAX_W:0]   kk;
    logic             found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      kk  = (MAX_W + 1)'(k);
      sum = {1'b0, ptr} + kk;
      if (sum >= n) sum = sum - n;
      if (kk < n && !found && req[sum[MAX_W-1:0]]) begin
        win   = sum[MAX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/countdown_sched_if.sv
// Requester-side bundle of the countdown scheduler.
interface countdown_sched_if #(
  parameter int N  = 4,
  parameter int dw = 8
);
  logic [N-1:0]    req;
  logic [N*dw-1:0] len;
  logic            pause;
  logic [N-1:0]    grant;
  logic            busy;
  logic [dw-1:0]   count;
  logic [N-1:0]    done;

  // Requester clients drive requests and observe the shared counter.
  modport master (
    output req, len, pause,
    input  grant, busy, count, done
  );

  // The scheduler consumes requests and reports ownership and status.
  modport slave (
    input  req, len, pause,
    output grant, busy, count, done
  );
endinterface

// File: rtl/countdown_sched_counter_load_down.sv
// Loadable down-counter: load has priority over enable; otherwise holds.
module counter_load_down #(
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [dw-1:0] load_val,
  input  logic          ena,
  output logic [dw-1:0] result
);

  // Counter register: reset to 0, then load > decrement > hold.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result <= '0;
    end else if (load) begin
      result <= load_val;
    end else if (ena) begin
      result <= result - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_sched.sv
// Round-robin scheduler sharing one loadable down-counter between N requesters.
module countdown_sched
  import countdown_pkg::*;
#(
  parameter int N  = 4,
  parameter int dw = 8
) (
  input logic               clk,
  input logic               reset,
  countdown_sched_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  sched_state_t  state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] owner_next;
  logic [N-1:0]  owner_oh;
  logic [dw-1:0] win_len;
  logic [dw-1:0] count;
  logic          any_req;
  logic          owner_req;
  logic          count_zero;
  logic          cnt_load;
  logic          cnt_ena;

  assign any_req    = |bus.req;
  assign owner_req  = bus.req[owner];
  assign count_zero = (count == '0);
  assign owner_next = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;

  // Arbitration and counter control, all from registered state plus inputs.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win_idx  = IW'(rr_pick(MAX_N'(bus.req), MAX_W'(rr_ptr), (MAX_W + 1)'(N)));
    win_len  = bus.len[int'(win_idx)*dw +: dw];
    cnt_load = (state == IDLE) && any_req;
    // Decrement never fires at 0: count_zero moves the FSM to DONE instead.
    cnt_ena  = (state == RUN) && owner_req && !count_zero && !bus.pause;
    owner_oh = '0;
    owner_oh[owner] = 1'b1;
  end

  // Scheduler FSM, owner register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= RUN;
            owner <= win_idx;
          end
        end
        RUN: begin
          if (!owner_req) begin
            state  <= IDLE;
            rr_ptr <= owner_next;
          end else if (count_zero) begin
            state <= DONE;
          end
        end
        DONE: begin
          state  <= IDLE;
          rr_ptr <= owner_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

  counter_load_down #(.dw(dw)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (win_len),
    .ena      (cnt_ena),
    .result   (count)
  );

  assign bus.grant = (state != IDLE) ? owner_oh : '0;
  assign bus.done  = (state == DONE) ? owner_oh : '0;
  assign bus.busy  = (state != IDLE);
  assign bus.count = count;

endmodule

// File: tb/tb_countdown_sched.sv
// Directed, table-driven bench for countdown_sched (N=4, dw=8).
module tb_countdown_sched;

  logic clk = 1'b0;
  logic reset = 1'b0;

  countdown_sched_if #(.N(4), .dw(8)) bus ();

  countdown_sched #(.N(4), .dw(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] len;
    logic        pause;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  count;
    logic [3:0]  done;
  } vec_t;

  vec_t tbl [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic b,
                            input logic [7:0] c, input logic [3:0] d);
    check({tag, " grant"}, 32'(bus.grant), 32'(g));
    check({tag, " busy"},  32'(bus.busy),  32'(b));
    check({tag, " count"}, 32'(bus.count), 32'(c));
    check({tag, " done"},  32'(bus.done),  32'(d));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    bus.req = 4'b0000;
    bus.pause = 1'b0;
    step();
    expect_out(tag, 4'b0000, 1'b0, 8'd0, 4'b0000);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] oh;
    bus.req = 4'b0000;
    bus.len = 32'h0;
    bus.pause = 1'b0;

    // Test 1: single request, len0=3.
    //          rst   req      len           pause grant    busy  count done
    tbl[0] = '{1'b0, 4'b0000, 32'h00000003, 1'b0, 4'b0000, 1'b0, 8'd0, 4'b0000};
    tbl[1] = '{1'b1, 4'b0001, 32'h00000003, 1'b0, 4'b0001, 1'b1, 8'd3, 4'b0000};
    tbl[2] = '{1'b1, 4'b0001, 32'h00000003, 1'b0, 4'b0001, 1'b1, 8'd2, 4'b0000};
    tbl[3] = '{1'b1, 4'b0001, 32'h00000003, 1'b0, 4'b0001, 1'b1, 8'd1, 4'b0000};
    tbl[4] = '{1'b1, 4'b0001, 32'h00000003, 1'b0, 4'b0001, 1'b1, 8'd0, 4'b0000};
    tbl[5] = '{1'b1, 4'b0001, 32'h00000003, 1'b0, 4'b0001, 1'b1, 8'd0, 4'b0001};
    tbl[6] = '{1'b1, 4'b0000, 32'h00000003, 1'b0, 4'b0000, 1'b0, 8'd0, 4'b0000};

    step();
    for (int i = 0; i < 7; i++) begin
      reset     = tbl[i].rst;
      bus.req   = tbl[i].req;
      bus.len   = tbl[i].len;
      bus.pause = tbl[i].pause;
      step();
      expect_out($sformatf("t1 row%0d", i), tbl[i].grant, tbl[i].busy, tbl[i].count, tbl[i].done);
    end

    // Test 2: all four request with len=1; grants rotate 0,1,2,3,0.
    do_reset("t2 reset");
    bus.len = 32'h01010101;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      step(); expect_out($sformatf("t2 g%0d run1", g), oh, 1'b1, 8'd1, 4'b0000);
      step(); expect_out($sformatf("t2 g%0d run0", g), oh, 1'b1, 8'd0, 4'b0000);
      step(); expect_out($sformatf("t2 g%0d done", g), oh, 1'b1, 8'd0, oh);
      step(); expect_out($sformatf("t2 g%0d idle", g), 4'b0000, 1'b0, 8'd0, 4'b0000);
    end

    // Test 3: len=4 with a 2-cycle pause; done moves from edge 6 to edge 8.
    do_reset("t3 reset");
    bus.len = 32'h00000004;
    bus.req = 4'b0001;
    step(); expect_out("t3 e1", 4'b0001, 1'b1, 8'd4, 4'b0000);
    step(); expect_out("t3 e2", 4'b0001, 1'b1, 8'd3, 4'b0000);
    bus.pause = 1'b1;
    step(); expect_out("t3 e3 paused", 4'b0001, 1'b1, 8'd3, 4'b0000);
    step(); expect_out("t3 e4 paused", 4'b0001, 1'b1, 8'd3, 4'b0000);
    bus.pause = 1'b0;
    step(); expect_out("t3 e5", 4'b0001, 1'b1, 8'd2, 4'b0000);
    step(); expect_out("t3 e6", 4'b0001, 1'b1, 8'd1, 4'b0000);
    step(); expect_out("t3 e7", 4'b0001, 1'b1, 8'd0, 4'b0000);
    step(); expect_out("t3 e8 done", 4'b0001, 1'b1, 8'd0, 4'b0001);
    bus.req = 4'b0000;
    step(); expect_out("t3 e9", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Test 4: owner 0 aborts at count=2; pending requester 1 is served next.
    do_reset("t4 reset");
    bus.len = 32'h00000205;
    bus.req = 4'b0011;
    step(); expect_out("t4 e1", 4'b0001, 1'b1, 8'd5, 4'b0000);
    step(); expect_out("t4 e2", 4'b0001, 1'b1, 8'd4, 4'b0000);
    step(); expect_out("t4 e3", 4'b0001, 1'b1, 8'd3, 4'b0000);
    step(); expect_out("t4 e4", 4'b0001, 1'b1, 8'd2, 4'b0000);
    bus.req = 4'b0010;
    step();
    check("t4 abort grant", 32'(bus.grant), 32'h0);
    check("t4 abort busy",  32'(bus.busy),  32'h0);
    check("t4 abort done",  32'(bus.done),  32'h0);
    step(); expect_out("t4 r1 e1", 4'b0010, 1'b1, 8'd2, 4'b0000);
    step(); expect_out("t4 r1 e2", 4'b0010, 1'b1, 8'd1, 4'b0000);
    step(); expect_out("t4 r1 e3", 4'b0010, 1'b1, 8'd0, 4'b0000);
    step(); expect_out("t4 r1 done", 4'b0010, 1'b1, 8'd0, 4'b0010);
    bus.req = 4'b0000;
    step(); expect_out("t4 idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Test 5a: len=0 gives one RUN cycle, then DONE.
    do_reset("t5 reset");
    bus.len = 32'h00000000;
    bus.req = 4'b0001;
    step(); expect_out("t5a run", 4'b0001, 1'b1, 8'd0, 4'b0000);
    step(); expect_out("t5a done", 4'b0001, 1'b1, 8'd0, 4'b0001);
    bus.req = 4'b0000;
    step(); expect_out("t5a idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Test 5b: requester 2, len=255: 256 RUN cycles, len change after load ignored.
    bus.len = 32'h00FF0000;
    bus.req = 4'b0100;
    step(); expect_out("t5b e1", 4'b0100, 1'b1, 8'd255, 4'b0000);
    for (int k = 2; k <= 256; k++) begin
      step();
      check($sformatf("t5b e%0d count", k), 32'(bus.count), 32'(256 - k));
      check($sformatf("t5b e%0d done", k),  32'(bus.done),  32'h0);
      if (k == 3) bus.len = 32'h00070000;
    end
    step(); expect_out("t5b done", 4'b0100, 1'b1, 8'd0, 4'b0100);
    bus.req = 4'b0000;
    step(); expect_out("t5b idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Test 6: reset mid-RUN clears everything and rr_ptr (requester 0 wins next).
    bus.len = 32'h06060606;
    bus.req = 4'b1111;
    step(); expect_out("t6 e1", 4'b1000, 1'b1, 8'd6, 4'b0000);
    step(); expect_out("t6 e2", 4'b1000, 1'b1, 8'd5, 4'b0000);
    reset = 1'b0;
    step(); expect_out("t6 reset", 4'b0000, 1'b0, 8'd0, 4'b0000);
    reset = 1'b1;
    step(); expect_out("t6 regrant", 4'b0001, 1'b1, 8'd6, 4'b0000);
    bus.req = 4'b0000;
    step(); expect_out("t6 abort", 4'b0000, 1'b0, 8'd6, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
